// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: delay/request inputs and sequenced reset outputs of rst_seq_ctrl
interface rst_seq_ctrl_if #(
  parameter int NUM_RST = 4,
  parameter int CNT_W   = 8
);
  logic [CNT_W-1:0]   i_dly;
  logic               i_sw_rst_req;
  logic               o_sw_rst_ack;
  logic [NUM_RST-1:0] o_rstn;
  logic               o_done;
  logic               o_busy;
  modport master (output i_dly, i_sw_rst_req, input o_sw_rst_ack, o_rstn, o_done, o_busy);
  modport slave  (input i_dly, i_sw_rst_req, output o_sw_rst_ack, o_rstn, o_done, o_busy);
endinterface

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases NUM_RST downstream resets in index order with a programmable gap,
// with software re-reset handshake and DFT/scan overrides
module rst_seq_ctrl #(
  parameter int NUM_RST = 4,
  parameter int CNT_W   = 8
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_dft_mode,
  input  logic i_dft_rstn,
  input  logic i_scan_mode,
  rst_seq_ctrl_if.slave bus
);
  localparam int IW = $clog2(NUM_RST);
  typedef enum logic [1:0] {LOAD, WAIT, DONE} state_t;
  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, d_m1;
  logic [NUM_RST-1:0] rstn_q, rstn_d;
  logic               done_q, done_d, busy_q, busy_d, ack_q, ack_d;
  logic               ctl_rstn;
  assign ctl_rstn = i_dft_mode ? i_dft_rstn : i_rstn;
  // a zero delay behaves as one cycle, so the reload value is max(i_dly,1)-1
  assign d_m1 = bus.i_dly - CNT_W'(bus.i_dly != '0);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rstn_d  = rstn_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    case (state_q)
      LOAD: begin
        cnt_d   = d_m1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          rstn_d[idx_q] = 1'b1;
          if (idx_q == IW'(NUM_RST - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IW'(1);
            cnt_d = d_m1;
          end
        end
      end
      default: state_d = state_q;
    endcase
    if (bus.i_sw_rst_req) begin
      rstn_d  = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
      idx_d   = '0;
      cnt_d   = d_m1;
      state_d = WAIT;
      ack_d   = 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge ctl_rstn)
    if (!ctl_rstn) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      rstn_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  assign bus.o_rstn       = i_scan_mode ? {NUM_RST{i_dft_rstn}} : rstn_q;
  assign bus.o_done       = done_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_sw_rst_ack = ack_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed literal checks plus randomized run against a release-time model
module tb_rst_seq_ctrl;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0, rstn = 1'b1, dft_mode = 1'b0, dft_rstn = 1'b1, scan = 1'b0;
  logic ctl_rstn;
  int total = 0, bad = 0, e = 0;
  rst_seq_ctrl_if #(.NUM_RST(N), .CNT_W(W)) bus ();
  rst_seq_ctrl #(.NUM_RST(N), .CNT_W(W)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_dft_mode(dft_mode), .i_dft_rstn(dft_rstn),
    .i_scan_mode(scan), .bus(bus)
  );
  assign ctl_rstn = dft_mode ? dft_rstn : rstn;
  always #5 clk = ~clk;
  // model: the time of the next release and which bit it frees
  logic [N-1:0] m_rstn;
  logic m_done, m_busy, m_ack, m_load;
  int t, next_t, k;
  initial begin
    m_rstn = '0; m_done = 0; m_busy = 1; m_ack = 0; m_load = 1; t = 0; next_t = 0; k = 0;
    forever begin
      @(posedge clk or negedge ctl_rstn);
      if (!ctl_rstn) begin
        m_rstn = '0; m_done = 0; m_busy = 1; m_ack = 0; m_load = 1;
      end else begin
        int d;
        d = (bus.i_dly == 0) ? 1 : int'(bus.i_dly);
        t++;
        m_ack = 0;
        if (bus.i_sw_rst_req) begin
          m_rstn = '0; m_done = 0; m_busy = 1; m_ack = 1; m_load = 0; k = 0; next_t = t + d;
        end else if (m_load) begin
          m_load = 0; k = 0; next_t = t + d;
        end else if (m_busy && t == next_t) begin
          m_rstn[k] = 1'b1;
          if (k == N - 1) begin m_done = 1; m_busy = 0; end
          else begin k++; next_t = t + d; end
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    chk("cyc_rstn", 32'(bus.o_rstn), 32'(scan ? {N{dft_rstn}} : m_rstn));
    chk("cyc_done", 32'(bus.o_done), 32'(m_done));
    chk("cyc_busy", 32'(bus.o_busy), 32'(m_busy));
    chk("cyc_ack", 32'(bus.o_sw_rst_ack), 32'(m_ack));
  end
  task automatic run_to(input int target);
    while (e < target) begin @(posedge clk); e++; end
    #1;
  endtask
  task automatic release_rst(input logic [W-1:0] dly);
    rstn = 1'b0;
    bus.i_dly = dly;
    @(posedge clk); #1;
    rstn = 1'b1;
    e = 0;
  endtask
  task automatic lit(input string nm, input logic [N-1:0] r, input logic dn, input logic by);
    chk({nm, "_rstn"}, 32'(bus.o_rstn), 32'(r));
    chk({nm, "_done"}, 32'(bus.o_done), 32'(dn));
    chk({nm, "_busy"}, 32'(bus.o_busy), 32'(by));
  endtask
  initial begin
    bus.i_dly = 8'd3; bus.i_sw_rst_req = 1'b0;
    #3 rstn = 1'b0;
    @(posedge clk); #1;
    release_rst(8'd3);
    lit("rst", 4'b0000, 0, 1);
    chk("rst_ack", 32'(bus.o_sw_rst_ack), 0);
    run_to(3);  lit("d3_e3", 4'b0000, 0, 1);
    run_to(4);  lit("d3_e4", 4'b0001, 0, 1);
    run_to(7);  lit("d3_e7", 4'b0011, 0, 1);
    run_to(10); lit("d3_e10", 4'b0111, 0, 1);
    run_to(12); lit("d3_e12", 4'b0111, 0, 1);
    run_to(13); lit("d3_e13", 4'b1111, 1, 0);
    release_rst(8'd0);
    run_to(1); lit("d0_e1", 4'b0000, 0, 1);
    run_to(2); lit("d0_e2", 4'b0001, 0, 1);
    run_to(3); lit("d0_e3", 4'b0011, 0, 1);
    run_to(4); lit("d0_e4", 4'b0111, 0, 1);
    run_to(5); lit("d0_e5", 4'b1111, 1, 0);
    release_rst(8'd2);
    run_to(19); lit("sw_e19", 4'b1111, 1, 0);
    bus.i_sw_rst_req = 1'b1;
    run_to(20); bus.i_sw_rst_req = 1'b0;
    lit("sw_e20", 4'b0000, 0, 1);
    chk("sw_ack20", 32'(bus.o_sw_rst_ack), 1);
    run_to(21); chk("sw_ack21", 32'(bus.o_sw_rst_ack), 0);
    lit("sw_e21", 4'b0000, 0, 1);
    run_to(22); lit("sw_e22", 4'b0001, 0, 1);
    run_to(23); lit("sw_e23", 4'b0001, 0, 1);
    run_to(24); lit("sw_e24", 4'b0011, 0, 1);
    run_to(26); lit("sw_e26", 4'b0111, 0, 1);
    run_to(28); lit("sw_e28", 4'b1111, 1, 0);
    release_rst(8'd5);
    run_to(11); lit("ar_e11", 4'b0011, 0, 1);
    run_to(13);
    #2 rstn = 1'b0;
    #1 lit("ar_async", 4'b0000, 0, 1);
    @(posedge clk); #1;
    rstn = 1'b1; e = 0;
    run_to(5); lit("ar_re5", 4'b0000, 0, 1);
    run_to(6); lit("ar_re6", 4'b0001, 0, 1);
    release_rst(8'd3);
    run_to(5); bus.i_dly = 8'd6;
    run_to(6);  lit("dc_e6", 4'b0001, 0, 1);
    run_to(7);  lit("dc_e7", 4'b0011, 0, 1);
    run_to(12); lit("dc_e12", 4'b0011, 0, 1);
    run_to(13); lit("dc_e13", 4'b0111, 0, 1);
    run_to(18); lit("dc_e18", 4'b0111, 0, 1);
    run_to(19); lit("dc_e19", 4'b1111, 1, 0);
    scan = 1'b1; dft_rstn = 1'b0;
    #1 chk("scan_lo", 32'(bus.o_rstn), 0);
    chk("scan_done", 32'(bus.o_done), 1);
    dft_rstn = 1'b1;
    #1 chk("scan_hi", 32'(bus.o_rstn), 32'hF);
    scan = 1'b0;
    #1 dft_mode = 1'b1; dft_rstn = 1'b0;
    bus.i_dly = 8'd5;
    e = 0;
    run_to(8); lit("dft_hold", 4'b0000, 0, 1);
    dft_rstn = 1'b1; e = 0;
    run_to(5); lit("dft_e5", 4'b0000, 0, 1);
    run_to(6); lit("dft_e6", 4'b0001, 0, 1);
    rstn = 1'b1;
    #1 dft_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      bus.i_dly = W'($urandom_range(0, 4));
      bus.i_sw_rst_req = ($urandom_range(0, 24) == 0);
      rstn = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk); #2;
    rstn = 1'b1; bus.i_sw_rst_req = 1'b0;
    repeat (4) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Sequenced reset release controller for the CRG. It takes one reset that has already been synchronised to its clock and fans it out to NUM_RST downstream domain resets. Each downstream reset is released in index order, with a programmable gap between releases. It also supports a software-requested full re-reset with an ack handshake, and carries the same DFT/scan reset overrides used elsewhere in the CRG.

Parameters:
NUM_RST, 4, number of sequenced reset outputs (min 2)
CNT_W, 8, width of the step-delay counter and of i_dly

Ports:
i_clk  input  1  controller clock
i_rstn  input  1  asynchronous active-low reset, already synchronised on release
i_dft_mode  input  1  1: i_dft_rstn replaces i_rstn as the controller's async reset
i_dft_rstn  input  1  DFT reset (active-low)
i_scan_mode  input  1  1: every o_rstn bit is driven directly from i_dft_rstn
i_dly  input  CNT_W  cycles between consecutive releases; a value of 0 is treated as 1
i_sw_rst_req  input  1  single-cycle pulse requesting a full re-reset sequence
o_sw_rst_ack  output  1  one-cycle pulse when a request is accepted
o_rstn  output  NUM_RST  sequenced active-low resets; bit 0 is released first
o_done  output  1  1 when all outputs are released
o_busy  output  1  1 while a sequence is in progress

Behaviour:
- Effective async reset: ctl_rstn = i_dft_mode ? i_dft_rstn : i_rstn.
- While ctl_rstn=0:
  - state=LOAD, idx=0, cnt=0
  - o_rstn=all 0, o_done=0, o_busy=1, o_sw_rst_ack=0
  - assertion of ctl_rstn takes effect immediately, in any state.
- D = (i_dly==0) ? 1 : i_dly. i_dly is sampled only when the counter loads, so a change mid-step has no effect until the next load.
- FSM states:
  - LOAD: cnt <= D-1, then go to WAIT.
  - WAIT:
    - If cnt!=0: cnt <= cnt-1.
    - If cnt==0: o_rstn[idx] <= 1.
      - If idx==NUM_RST-1: o_done <= 1, o_busy <= 0, go to DONE.
      - Otherwise: idx <= idx+1, cnt <= D-1, stay in WAIT.
  - DONE: hold all outputs; wait for i_sw_rst_req.
- Release timing: counting rising edges from the first edge after ctl_rstn deasserts as edge 1, o_rstn[k] rises at edge (k+1)*D+1. o_done rises on the same edge as o_rstn[NUM_RST-1].
- Outputs never release out of order. A released bit stays high until a new sequence or an async reset.
- Software request (i_sw_rst_req=1 sampled at edge E, in any state):
  - At edge E: o_rstn <= all 0, o_done <= 0, o_busy <= 1, idx <= 0, cnt <= D-1, state <= WAIT, o_sw_rst_ack <= 1. o_sw_rst_ack returns to 0 at edge E+1.
  - o_rstn[k] then rises at edge E+(k+1)*D.
  - A request arriving mid-sequence, or while in LOAD, restarts the sequence from idx 0 and is still acked.
  - Back-to-back requests each produce an ack and each restart the count.
- Scan override: o_rstn = i_scan_mode ? {NUM_RST{i_dft_rstn}} : o_rstn_q. This mux is combinational and is the only combinational path to o_rstn; o_done, o_busy and o_sw_rst_ack stay registered.
- cnt never wraps: it is only decremented when non-zero.
- idx never exceeds NUM_RST-1.

Test Plan:
- NUM_RST=4, i_dly=3, release i_rstn -> o_rstn goes 0001@edge4, 0011@7, 0111@10, 1111@13; o_done=1 and o_busy=0 @13.
- i_dly=0 -> handled as D=1: o_rstn bits rise at edges 2,3,4,5.
- Sequence complete with i_dly=2; pulse i_sw_rst_req at edge 20 -> o_rstn=0000 and o_sw_rst_ack=1 @20; ack=0 @21; bits rise @22,24,26,28.
- i_dly=5; after o_rstn=0011, drop i_rstn asynchronously mid-count -> o_rstn=0000, o_done=0 with no clock edge; on re-release, sequence restarts from bit 0 @edge6.
- i_dly changed 3->6 during step 1 -> step 1 completes with D=3; step 2 uses D=6.
- i_scan_mode=1: toggle i_dft_rstn -> o_rstn follows it combinationally as 0000/1111. With i_dft_mode=1 and i_dft_rstn=0 -> FSM held in reset.
